// File: rtl/trivium_stream_ctrl_if.sv
// Control and keystream byte handshake between a Trivium stream controller
// (slave) and the block that drives it (master).
interface trivium_stream_ctrl_if;
   logic        start;
   logic        stop;
   logic [79:0] key;
   logic [79:0] iv;
   logic        busy;
   logic        ks_valid;
   logic        ks_ready;
   logic [7:0]  ks_data;

   modport master (
      output start, stop, key, iv, ks_ready,
      input  busy, ks_valid, ks_data
   );

   modport slave (
      input  start, stop, key, iv, ks_ready,
      output busy, ks_valid, ks_data
   );
endinterface

// File: rtl/trivium_stream_ctrl.sv
// Trivium keystream controller: loads key/iv, discards the warm-up output,
// then packs keystream bits (first bit in bit 0) into bytes behind valid/ready.
module trivium_stream_ctrl #(
   parameter int unsigned WARMUP_STEPS = 1152
) (
   input  logic                 clk,
   input  logic                 reset,
   trivium_stream_ctrl_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(WARMUP_STEPS + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WARMUP = 2'd1,
      RUN    = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wcnt_q, wcnt_d;
   logic [92:0]      a_q, a_d;
   logic [83:0]      b_q, b_d;
   logic [110:0]     c_q, c_d;
   logic [2:0]       n_q, n_d;
   logic [6:0]       col_q, col_d;
   logic [7:0]       data_q, data_d;
   logic             vld_q, vld_d;

   logic ks_bit, t1, t2, t3;
   logic step, load;

   // Register index k holds Trivium cell A[k]/B[k]/C[k]; a step shifts toward higher k.
   assign ks_bit = a_q[65] ^ a_q[92] ^ b_q[68] ^ b_q[83] ^ c_q[65] ^ c_q[110];
   assign t1     = a_q[65] ^ a_q[92] ^ (a_q[90] & a_q[91]) ^ b_q[77];
   assign t2     = b_q[68] ^ b_q[83] ^ (b_q[81] & b_q[82]) ^ c_q[86];
   assign t3     = c_q[65] ^ c_q[110] ^ (c_q[108] & c_q[109]) ^ a_q[68];

   assign bus.busy     = (state_q != IDLE);
   assign bus.ks_valid = vld_q;
   assign bus.ks_data  = data_q;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      n_d     = n_q;
      col_d   = col_q;
      data_d  = data_q;
      vld_d   = vld_q;
      step    = 1'b0;
      load    = 1'b0;

      if (bus.stop) begin
         state_d = IDLE;
         vld_d   = 1'b0;
         n_d     = 3'd0;
         col_d   = '0;
      end else if (bus.start) begin
         load    = 1'b1;
         state_d = WARMUP;
         wcnt_d  = '0;
         vld_d   = 1'b0;
         n_d     = 3'd0;
         col_d   = '0;
      end else begin
         case (state_q)
            IDLE: state_d = IDLE;
            WARMUP: begin
               step   = 1'b1;
               wcnt_d = wcnt_q + CNT_W'(1);
               if (wcnt_d == CNT_W'(WARMUP_STEPS)) begin
                  state_d = RUN;
                  n_d     = 3'd0;
                  col_d   = '0;
               end
            end
            RUN: begin
               if (vld_q && bus.ks_ready) vld_d = 1'b0;
               // The eighth bit is only produced once the output register can take the byte.
               if (n_q != 3'd7) begin
                  step       = 1'b1;
                  col_d[n_q] = ks_bit;
                  n_d        = n_q + 3'd1;
               end else if (!vld_q || bus.ks_ready) begin
                  step   = 1'b1;
                  data_d = {ks_bit, col_q};
                  vld_d  = 1'b1;
                  n_d    = 3'd0;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      a_d = a_q;
      b_d = b_q;
      c_d = c_q;
      if (load) begin
         a_d = {13'd0, bus.iv};
         b_d = {4'd0, bus.key};
         c_d = {3'b111, 108'd0};
      end else if (step) begin
         a_d = {a_q[91:0], t3};
         b_d = {b_q[82:0], t1};
         c_d = {c_q[109:0], t2};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         n_q     <= 3'd0;
         col_q   <= '0;
         data_q  <= 8'h00;
         vld_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         n_q     <= n_d;
         col_q   <= col_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
      end
   end
endmodule

// File: tb/tb_trivium_stream_ctrl.sv
// Self-checking bench for trivium_stream_ctrl: a reference Trivium model fills a
// byte scoreboard that is drained on every ks_valid && ks_ready transfer.
module tb_trivium_stream_ctrl;
   localparam int WU  = 1152;
   localparam int LAT = WU + 8;

   logic clk = 1'b0;
   logic reset;

   trivium_stream_ctrl_if bus ();

   trivium_stream_ctrl #(.WARMUP_STEPS(WU)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   bit         s[1:288];

   // Reference model in the conventional s1..s288 numbering.
   task automatic model_step(output bit z);
      bit t1, t2, t3;
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 93; i >= 2; i--) s[i] = s[i-1];
      s[1] = t3;
      for (int i = 177; i >= 95; i--) s[i] = s[i-1];
      s[94] = t1;
      for (int i = 288; i >= 179; i--) s[i] = s[i-1];
      s[178] = t2;
   endtask

   task automatic model_load(input logic [79:0] k, input logic [79:0] v);
      bit z;
      for (int i = 1; i <= 288; i++) s[i] = 1'b0;
      for (int i = 0; i < 80; i++) begin
         s[i+1]  = v[i];
         s[94+i] = k[i];
      end
      s[286] = 1'b1;
      s[287] = 1'b1;
      s[288] = 1'b1;
      for (int i = 0; i < WU; i++) model_step(z);
   endtask

   task automatic model_push(input int n);
      for (int i = 0; i < n; i++) begin
         logic [7:0] b;
         bit z;
         b = '0;
         for (int j = 0; j < 8; j++) begin
            model_step(z);
            b[j] = z;
         end
         exp_q.push_back(b);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the start edge.
   task automatic do_start(input logic [79:0] k, input logic [79:0] v);
      bus.key   = k;
      bus.iv    = v;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic test_reset;
      reset        = 1'b1;
      bus.start    = 1'b1;
      bus.stop     = 1'b1;
      bus.key      = '1;
      bus.iv       = '1;
      bus.ks_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_cmp++;
      if (bus.ks_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.ks_valid); end
      n_cmp++;
      if (bus.ks_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", bus.ks_data); end
      reset     = 1'b0;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_after_reset: busy got %b want 0", bus.busy); end
   endtask

   task automatic test_ready_high;
      int cyc;
      int got;
      bit found;
      exp_q.delete();
      model_load(80'h0, 80'h0);
      model_push(64);
      bus.ks_ready = 1'b1;
      do_start(80'h0, 80'h0);
      n_cmp++;
      if (bus.busy !== 1'b1) begin n_err++; $display("FAIL start_busy: got %b want 1", bus.busy); end
      cyc   = 0;
      found = 1'b0;
      while (!found && cyc < LAT + 20) begin
         @(negedge clk);
         cyc++;
         if (bus.ks_valid) found = 1'b1;
      end
      n_cmp++;
      if (cyc != LAT) begin n_err++; $display("FAIL first_latency: got %0d want %0d", cyc, LAT); end
      got = 0;
      while (got < 64 && cyc < LAT + 8 * 64 + 16) begin
         if (bus.ks_valid) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_cmp++;
            if (cyc != LAT + 8 * got) begin
               n_err++;
               $display("FAIL byte_spacing[%0d]: got cycle %0d want %0d", got, cyc, LAT + 8 * got);
            end
            n_cmp++;
            if (bus.ks_data !== e) begin n_err++; $display("FAIL zero_key_byte[%0d]: got %h want %h", got, bus.ks_data, e); end
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (got != 64) begin n_err++; $display("FAIL zero_key_count: got %0d want 64", got); end
   endtask

   task automatic test_backpressure;
      logic [79:0] k, v;
      logic [7:0]  first, e;
      int          cyc, got;
      bit          found, stable;
      k = 80'h0123456789ABCDEF0123;
      v = 80'hFFFF0000FFFF0000FFFF;
      exp_q.delete();
      model_load(k, v);
      model_push(40);
      bus.ks_ready = 1'b0;
      do_start(k, v);
      cyc   = 0;
      found = 1'b0;
      while (!found && cyc < LAT + 20) begin
         @(negedge clk);
         cyc++;
         if (bus.ks_valid) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin n_err++; $display("FAIL bp_first_valid: got none want valid by %0d", LAT + 20); end
      first  = bus.ks_data;
      stable = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (!bus.ks_valid || bus.ks_data !== first) stable = 1'b0;
      end
      n_cmp++;
      if (!stable) begin n_err++; $display("FAIL bp_hold: got change while stalled want stable %h", first); end
      bus.ks_ready = 1'b1;
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.ks_data !== e) begin n_err++; $display("FAIL bp_byte[0]: got %h want %h", bus.ks_data, e); end
      @(negedge clk);
      n_cmp++;
      if (bus.ks_valid !== 1'b1) begin n_err++; $display("FAIL bp_next_valid: got %b want 1", bus.ks_valid); end
      got = 1;
      cyc = 0;
      while (got < 40 && cyc < 8 * 40 + 16) begin
         if (bus.ks_valid) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.ks_data !== e) begin n_err++; $display("FAIL bp_byte[%0d]: got %h want %h", got, bus.ks_data, e); end
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (got != 40) begin n_err++; $display("FAIL bp_count: got %0d want 40", got); end
   endtask

   task automatic test_random_ready;
      logic [79:0] k, v;
      logic [7:0]  prev_data, e;
      bit          prev_valid, prev_ready, r;
      int          cyc, got, stab_err;
      k = 80'h3C5A_9F00_1E2D_4B6C_7788;
      v = 80'h0011_2233_4455_6677_8899;
      exp_q.delete();
      model_load(k, v);
      model_push(256);
      bus.ks_ready = 1'b0;
      do_start(k, v);
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_data  = 8'h00;
      got        = 0;
      cyc        = 0;
      stab_err   = 0;
      while (got < 256 && cyc < LAT + 256 * 40) begin
         if (prev_valid && !prev_ready && (!bus.ks_valid || bus.ks_data !== prev_data)) stab_err++;
         r            = 1'($urandom_range(0, 1));
         bus.ks_ready = r;
         if (bus.ks_valid && r) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.ks_data !== e) begin n_err++; $display("FAIL rnd_byte[%0d]: got %h want %h", got, bus.ks_data, e); end
            got++;
         end
         prev_valid = bus.ks_valid;
         prev_ready = r;
         prev_data  = bus.ks_data;
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (got != 256) begin n_err++; $display("FAIL rnd_count: got %0d want 256", got); end
      n_cmp++;
      if (stab_err != 0) begin n_err++; $display("FAIL rnd_hold: got %0d unstable stalls want 0", stab_err); end
   endtask

   task automatic test_restart;
      logic [79:0] k1, k2, v;
      logic [7:0]  e;
      int          cyc, got;
      bit          found;
      k1 = 80'hDEADBEEFCAFEF00D1234;
      k2 = 80'h0F1E2D3C4B5A69788796;
      v  = 80'hA5A5_5A5A_0102_0304_0506;
      exp_q.delete();
      model_load(k1, v);
      model_push(10);
      bus.ks_ready = 1'b1;
      do_start(k1, v);
      got = 0;
      cyc = 0;
      while (got < 10 && cyc < LAT + 8 * 10 + 16) begin
         @(negedge clk);
         cyc++;
         if (bus.ks_valid) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.ks_data !== e) begin n_err++; $display("FAIL rs_old_byte[%0d]: got %h want %h", got, bus.ks_data, e); end
            got++;
         end
      end
      found = 1'b0;
      while (!found && cyc < LAT + 8 * 12 + 16) begin
         @(negedge clk);
         cyc++;
         if (bus.ks_valid) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin n_err++; $display("FAIL rs_byte10_valid: got none want valid"); end
      // Restart while byte 10 is presented but not accepted.
      bus.ks_ready = 1'b0;
      exp_q.delete();
      model_load(k2, v);
      model_push(8);
      do_start(k2, v);
      bus.ks_ready = 1'b1;
      n_cmp++;
      if (bus.ks_valid !== 1'b0) begin n_err++; $display("FAIL rs_valid_clear: got %b want 0", bus.ks_valid); end
      n_cmp++;
      if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rs_busy: got %b want 1", bus.busy); end
      cyc   = 0;
      found = 1'b0;
      while (!found && cyc < LAT + 20) begin
         @(negedge clk);
         cyc++;
         if (bus.ks_valid) found = 1'b1;
      end
      n_cmp++;
      if (cyc != LAT) begin n_err++; $display("FAIL rs_latency: got %0d want %0d", cyc, LAT); end
      got = 0;
      cyc = 0;
      while (got < 8 && cyc < 8 * 8 + 16) begin
         if (bus.ks_valid) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.ks_data !== e) begin n_err++; $display("FAIL rs_new_byte[%0d]: got %h want %h", got, bus.ks_data, e); end
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (got != 8) begin n_err++; $display("FAIL rs_count: got %0d want 8", got); end
   endtask

   task automatic test_stop;
      bit seen;
      bit found;
      int cyc;
      bus.ks_ready = 1'b1;
      do_start(80'h1111_2222_3333_4444_5555, 80'h6666_7777_8888_9999_AAAA);
      repeat (499) @(negedge clk);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      n_cmp++;
      if (bus.busy !== 1'b0) begin n_err++; $display("FAIL stop_warmup_busy: got %b want 0", bus.busy); end
      seen = 1'b0;
      repeat (LAT + 40) begin
         @(negedge clk);
         if (bus.ks_valid || bus.busy) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin n_err++; $display("FAIL stop_warmup_quiet: got activity want none"); end

      bus.key   = 80'h1234;
      bus.iv    = 80'h5678;
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      n_cmp++;
      if (bus.busy !== 1'b0) begin n_err++; $display("FAIL start_stop_busy: got %b want 0", bus.busy); end
      seen = 1'b0;
      repeat (LAT + 40) begin
         @(negedge clk);
         if (bus.ks_valid || bus.busy) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin n_err++; $display("FAIL start_stop_quiet: got activity want none"); end

      bus.ks_ready = 1'b0;
      do_start(80'hFEDC, 80'hBA98);
      cyc   = 0;
      found = 1'b0;
      while (!found && cyc < LAT + 20) begin
         @(negedge clk);
         cyc++;
         if (bus.ks_valid) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin n_err++; $display("FAIL stop_run_valid: got none want valid"); end
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      n_cmp++;
      if (bus.ks_valid !== 1'b0 || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL stop_run_clear: got valid=%b busy=%b want 0/0", bus.ks_valid, bus.busy);
      end
   endtask

   task automatic test_reset_mid_run;
      bit found;
      bit seen;
      int cyc;
      bus.ks_ready = 1'b0;
      do_start(80'hABCD_EF01_2345_6789_ABCD, 80'h1357_9BDF_0246_8ACE_1357);
      cyc   = 0;
      found = 1'b0;
      while (!found && cyc < LAT + 20) begin
         @(negedge clk);
         cyc++;
         if (bus.ks_valid) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin n_err++; $display("FAIL rst_run_valid: got none want valid"); end
      reset     = 1'b1;
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.ks_valid !== 1'b0 || bus.ks_data !== 8'h00) begin
         n_err++;
         $display("FAIL rst_run_clear: got busy=%b valid=%b data=%h want 0/0/00", bus.busy, bus.ks_valid, bus.ks_data);
      end
      bus.ks_ready = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.ks_valid || bus.busy) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin n_err++; $display("FAIL rst_run_quiet: got activity want none"); end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish want finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_ready_high();
      test_backpressure();
      test_random_ready();
      test_restart();
      test_stop();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
